// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and index helpers
// Purpose : constants and functions shared by the FFT pipeline stages.
// Ports   : none (package).
package fft_pkg;

    // Default width of one real or imaginary component of a complex sample.
    localparam int CPLX_W = 16;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    // Callers truncate the result to their own index width.
    function automatic int unsigned bit_reverse(input int unsigned v, input int unsigned n);
        int unsigned r;
        logic [4:0]  idx;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                idx  = 5'(n - 1 - i);
                r[i] = v[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with registered read port
// Purpose : one write port and one read port; read data is registered.
// Ports   : clock_i/reset_i    - clock and synchronous active-high reset
//           we_i/waddr_i/wdata_i - write port
//           re_i/raddr_i/rdata_o - read port, rdata_o valid one cycle after re_i
module sdp_ram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array is deliberately not reset.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register is cleared so the downstream outputs read zero after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bit_reverse_reorder.sv
// rtl/bit_reverse_reorder.sv - bit-reversed to natural order frame reorder
// Purpose : stores each N-point frame at bit-reversed addresses in one half of
//           a ping-pong buffer and reads it back in natural order while the
//           next frame fills the other half.
// Ports   : clock/reset          - clock and synchronous active-high reset
//           di_en/di_re/di_im    - input sample stream (bit-reversed order)
//           do_en/do_first       - output valid and first-of-frame marker
//           do_re/do_im          - output sample stream (natural order)
module bit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int LOG_N = 6,
    parameter int WIDTH = CPLX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic             do_first,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_READ = 1'b1;
    localparam logic [LOG_N-1:0] LAST    = {LOG_N{1'b1}};

    logic [LOG_N-1:0] wcnt_q,  wcnt_d;
    logic [LOG_N-1:0] raddr_q, raddr_d;
    logic             wsel_q,  wsel_d;
    logic             rsel_q,  rsel_d;
    logic [0:0]       state_q, state_d;
    logic             do_en_q, do_first_q;

    logic             frame_done;
    logic             ram_we;
    logic [LOG_N-1:0] waddr;
    logic [2*WIDTH-1:0] rdata;

    assign frame_done = di_en && (wcnt_q == LAST);
    assign waddr      = LOG_N'(bit_reverse(32'(wcnt_q), LOG_N));
    // Samples presented while reset is high must not land in the buffer.
    assign ram_we     = di_en && !reset;

    always_comb begin
        wcnt_d  = wcnt_q;
        wsel_d  = wsel_q;
        state_d = state_q;
        raddr_d = raddr_q;
        rsel_d  = rsel_q;

        if (di_en) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        if (frame_done) begin
            // A completion can coincide with the last read address of the
            // previous frame; restarting here keeps the output gapless.
            wsel_d  = ~wsel_q;
            state_d = ST_READ;
            raddr_d = '0;
            rsel_d  = wsel_q;
        end else if (state_q == ST_READ) begin
            if (raddr_q == LAST) begin
                state_d = ST_IDLE;
                raddr_d = '0;
            end else begin
                raddr_d = raddr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q     <= '0;
            wsel_q     <= 1'b0;
            state_q    <= ST_IDLE;
            raddr_q    <= '0;
            rsel_q     <= 1'b0;
            do_en_q    <= 1'b0;
            do_first_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            wsel_q     <= wsel_d;
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            rsel_q     <= rsel_d;
            // Valid flags follow the address by one cycle, matching the RAM read register.
            do_en_q    <= (state_q == ST_READ);
            do_first_q <= (state_q == ST_READ) && (raddr_q == '0);
        end
    end

    // Both banks share one array; the bank select is the address MSB.
    sdp_ram #(
        .AW (LOG_N + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clock_i (clock),
        .reset_i (reset),
        .we_i    (ram_we),
        .waddr_i ({wsel_q, waddr}),
        .wdata_i ({di_re, di_im}),
        .re_i    (state_q == ST_READ),
        .raddr_i ({rsel_q, raddr_q}),
        .rdata_o (rdata)
    );

    assign do_en    = do_en_q;
    assign do_first = do_first_q;
    assign do_re    = rdata[2*WIDTH-1:WIDTH];
    assign do_im    = rdata[WIDTH-1:0];

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// tb/tb_bit_reverse_reorder.sv - scoreboard bench for bit_reverse_reorder
module tb_bit_reverse_reorder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;
    logic        do_en;
    logic        do_first;
    logic [15:0] do_re;
    logic [15:0] do_im;

    bit_reverse_reorder #(.LOG_N(3), .WIDTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_en    (do_en),
        .do_first (do_first),
        .do_re    (do_re),
        .do_im    (do_im)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        first;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   br[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected sample per valid output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (do_en === 1'b1) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual re=%h im=%h required none at %0t",
                             do_re, do_im, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_re", 32'(do_re), 32'(e.re));
                    chk("out_im", 32'(do_im), 32'(e.im));
                    chk("out_first", 32'(do_first), 32'(e.first));
                end
            end else begin
                chk("first_without_en", 32'(do_first), 32'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic drive(input logic en, input logic [15:0] re, input logic [15:0] im);
        di_en = en;
        di_re = re;
        di_im = im;
        @(posedge clock);
        #1;
        di_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic push_frame(input int base);
        logic [15:0] v;
        for (int q = 0; q < 8; q++) begin
            v = 16'(base + q);
            exp_q.push_back('{re: v, im: -v, first: (q == 0)});
        end
    endtask

    task automatic send_frame(input int base);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 16'(base + br[i]);
            drive(1'b1, v, -v);
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] ext_re[8];
        logic [15:0] ext_im[8];
        ext_re = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        ext_im = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

        // Reset with di_en held high: samples must be ignored.
        di_en = 1'b1;
        di_re = 16'h1234;
        di_im = 16'h5678;
        repeat (4) @(posedge clock);
        #1;
        chk("rst_do_en", 32'(do_en), 32'(0));
        chk("rst_do_first", 32'(do_first), 32'(0));
        chk("rst_do_re", 32'(do_re), 32'(0));
        chk("rst_do_im", 32'(do_im), 32'(0));
        reset = 1'b0;
        di_en = 1'b0;
        idle(2);

        // Single frame with latency checks.
        push_frame(0);
        send_frame(0);
        chk("lat_pre_en", 32'(do_en), 32'(0));
        idle(1);
        chk("lat_en", 32'(do_en), 32'(1));
        chk("lat_first", 32'(do_first), 32'(1));
        idle(7);
        chk("tail_en", 32'(do_en), 32'(1));
        chk("tail_first", 32'(do_first), 32'(0));
        idle(1);
        chk("tail_drop", 32'(do_en), 32'(0));
        idle(3);

        // Four frames back-to-back: output must be gapless.
        for (int f = 0; f < 4; f++) push_frame(8 * f);
        for (int gi = 0; gi < 32; gi++) begin
            v = 16'((gi / 8) * 8 + br[gi % 8]);
            drive(1'b1, v, -v);
            if (gi >= 8) chk("b2b_en", 32'(do_en), 32'(1));
        end
        for (int j = 0; j < 8; j++) begin
            idle(1);
            chk("b2b_tail_en", 32'(do_en), 32'(1));
        end
        idle(1);
        chk("b2b_drop", 32'(do_en), 32'(0));
        idle(3);

        // Bursty input: one sample then two idle cycles.
        push_frame(0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(br[i]), -16'(br[i]));
            if (i < 7) idle(2);
        end
        chk("burst_pre_en", 32'(do_en), 32'(0));
        idle(1);
        chk("burst_en", 32'(do_en), 32'(1));
        chk("burst_first", 32'(do_first), 32'(1));
        idle(10);

        // Extreme values alternate in input order.
        for (int q = 0; q < 8; q++) exp_q.push_back('{re: ext_re[q], im: ext_im[q], first: (q == 0)});
        for (int p = 0; p < 8; p++) begin
            if (p % 2 == 0) drive(1'b1, 16'h7FFF, 16'h8000);
            else            drive(1'b1, 16'h8000, 16'h7FFF);
        end
        idle(10);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h100 + i), 16'(16'h200 + i));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        push_frame(16);
        send_frame(16);
        idle(12);

        // Reset mid-readout after three output samples.
        push_frame(32);
        send_frame(32);
        idle(3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        chk("rro_en", 32'(do_en), 32'(0));
        chk("rro_first", 32'(do_first), 32'(0));
        chk("rro_re", 32'(do_re), 32'(0));
        chk("rro_im", 32'(do_im), 32'(0));
        reset = 1'b0;
        idle(2);
        chk("rro_stay_low", 32'(do_en), 32'(0));
        push_frame(40);
        send_frame(40);
        idle(12);

        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        chk("out_count", 32'(n_out), 32'(75));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
